mv_pred_decode: RTL and testbench

MV_PRED_DECODE -- requirements
Module: mv_pred_decode

---
 rtl/mv_pred_decode.sv | 173 +++++++++++++++++
 tb/tb_mv_pred_decode.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mv_pred_decode.sv
// Motion-vector predictor decoder: decodes one MPEG-2 motion_code VLC plus residual
// from a bitstream window and reconstructs the vector against a per-channel predictor.
module mv_pred_decode #(
  parameter int BUF_W  = 24,
  parameter int NUM_CH = 4,
  parameter int CHW    = 2,
  parameter int MV_W   = 14
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [BUF_W-1:0]       buf_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [CHW-1:0]         ch_i,
  input  logic [3:0]             f_code_i,
  input  logic                   pmv_clear_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [4:0]             outshift_o,
  output logic signed [4:0]      mcode_o,
  output logic signed [MV_W-1:0] mv_o,
  output logic                   err_o,
  output logic [1:0]             state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and outputs stay frozen while out_valid_o=1 and out_ready_i=0.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam int SW = MV_W + 1;
  localparam logic signed [SW-1:0] ONE = 1;

  logic [1:0]             state_q, state_d;
  logic [BUF_W-1:0]       buf_q;
  logic [CHW-1:0]         ch_q;
  logic [3:0]             fcode_q;
  logic signed [MV_W-1:0] pmv_q [NUM_CH];
  logic                   out_valid_q, err_q;
  logic [4:0]             outshift_q;
  logic signed [4:0]      mcode_q;
  logic signed [MV_W-1:0] mv_q;

  logic [9:0]       pfx;
  logic [4:0]       mag;
  logic [3:0]       len_m1;
  logic             code_ok;
  logic [BUF_W-1:0] shl_s, shl_r;
  logic             neg;
  logic [3:0]       r_size;
  logic [7:0]       residual;
  logic [4:0]       vlc_len, outshift_n;
  logic signed [4:0] mcode_n;
  logic             f_ok, ch_ok, legal;
  logic signed [MV_W-1:0] base;
  logic signed [SW-1:0] dabs, delta, sum, sum_w, f16, hi, lo, f32;

  assign pfx = buf_q[BUF_W-1 -: 10];

  // Magnitude and VLC length minus one (sign bit included in the length).
  always_comb begin
    mag     = 5'd0;
    len_m1  = 4'd0;
    code_ok = 1'b1;
    casez (pfx)
      10'b1?????????: begin mag = 5'd0;  len_m1 = 4'd0;  end
      10'b01????????: begin mag = 5'd1;  len_m1 = 4'd2;  end
      10'b001???????: begin mag = 5'd2;  len_m1 = 4'd3;  end
      10'b0001??????: begin mag = 5'd3;  len_m1 = 4'd4;  end
      10'b000011????: begin mag = 5'd4;  len_m1 = 4'd6;  end
      10'b0000101???: begin mag = 5'd5;  len_m1 = 4'd7;  end
      10'b0000100???: begin mag = 5'd6;  len_m1 = 4'd7;  end
      10'b0000011???: begin mag = 5'd7;  len_m1 = 4'd7;  end
      10'b000001011?: begin mag = 5'd8;  len_m1 = 4'd9;  end
      10'b000001010?: begin mag = 5'd9;  len_m1 = 4'd9;  end
      10'b000001001?: begin mag = 5'd10; len_m1 = 4'd9;  end
      10'b000001000?: begin mag = 5'd11; len_m1 = 4'd9;  end
      10'b0000001111: begin mag = 5'd12; len_m1 = 4'd10; end
      10'b0000001110: begin mag = 5'd13; len_m1 = 4'd10; end
      10'b0000001101: begin mag = 5'd14; len_m1 = 4'd10; end
      10'b0000001100: begin mag = 5'd15; len_m1 = 4'd10; end
      10'b0000001011: begin mag = 5'd16; len_m1 = 4'd10; end
      default:        code_ok = 1'b0;
    endcase
  end

  assign shl_s    = buf_q << len_m1;
  assign shl_r    = shl_s << 1;
  assign neg      = (mag != 5'd0) && shl_s[BUF_W-1];
  assign r_size   = fcode_q - 4'd1;
  assign residual = shl_r[BUF_W-1 -: 8] >> (4'd8 - r_size);
  assign vlc_len  = {1'b0, len_m1} + 5'd1;
  assign outshift_n = vlc_len + ((mag != 5'd0) ? {1'b0, r_size} : 5'd0);
  // +16 has no 5-bit signed encoding and aliases to -16 on mcode_o.
  assign mcode_n  = neg ? -mag : mag;

  assign f_ok  = (fcode_q >= 4'd1) && (fcode_q <= 4'd9);
  assign ch_ok = {1'b0, ch_q} < NUM_CH[CHW:0];
  assign legal = code_ok && f_ok && ch_ok;
  assign base  = (pmv_clear_i || !ch_ok) ? '0 : pmv_q[ch_q];

  always_comb begin
    dabs  = ((SW'(mag) - ONE) << r_size) + SW'(residual) + ONE;
    delta = (mag == 5'd0) ? '0 : (neg ? -dabs : dabs);
    sum   = {base[MV_W-1], base} + delta;
    f16   = ONE <<< (r_size + 4'd4);
    hi    = f16 - ONE;
    lo    = -f16;
    f32   = f16 <<< 1;
    sum_w = sum;
    if (sum > hi)      sum_w = sum - f32;
    else if (sum < lo) sum_w = sum + f32;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid_i) state_d = S_CALC;
      S_CALC:  state_d = S_HOLD;
      S_HOLD:  if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      ch_q        <= '0;
      fcode_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      outshift_q  <= '0;
      mcode_q     <= '0;
      mv_q        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && in_valid_i) begin
        buf_q   <= buf_i;
        ch_q    <= ch_i;
        fcode_q <= f_code_i;
      end
      if (state_q == S_CALC) begin
        out_valid_q <= 1'b1;
        err_q       <= !legal;
        outshift_q  <= legal ? outshift_n : 5'd0;
        mcode_q     <= legal ? mcode_n : 5'sd0;
        mv_q        <= legal ? sum_w[MV_W-1:0] : base;
      end
      if (state_q == S_HOLD && out_ready_i) out_valid_q <= 1'b0;
    end
  end

  // A clear coinciding with CALC still lets the freshly computed vector land.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) pmv_q[i] <= '0;
    end else begin
      if (pmv_clear_i)
        for (int i = 0; i < NUM_CH; i++) pmv_q[i] <= '0;
      if (state_q == S_CALC && legal) pmv_q[ch_q] <= sum_w[MV_W-1:0];
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = out_valid_q;
  assign err_o       = err_q;
  assign outshift_o  = outshift_q;
  assign mcode_o     = mcode_q;
  assign mv_o        = mv_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mv_pred_decode.sv
// Directed bench for mv_pred_decode: expected {err, outshift, mcode, mv} vectors are
// queued as each request is driven and popped when the result appears.
module tb_mv_pred_decode;
  localparam int BUF_W = 24;
  localparam int W     = 25;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [BUF_W-1:0]  buf_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [1:0]        ch_i;
  logic [3:0]        f_code_i;
  logic              pmv_clear_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [4:0]        outshift_o;
  logic signed [4:0] mcode_o;
  logic signed [13:0] mv_o;
  logic              err_o;
  logic [1:0]        state_o;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  mv_pred_decode dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .buf_i(buf_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .ch_i(ch_i), .f_code_i(f_code_i), .pmv_clear_i(pmv_clear_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .outshift_o(outshift_o),
    .mcode_o(mcode_o), .mv_o(mv_o), .err_o(err_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] ex(input logic e, input int os, input int mc, input int mv);
    logic [4:0]  o5;
    logic [4:0]  m5;
    logic [13:0] v14;
    o5  = os[4:0];
    m5  = mc[4:0];
    v14 = mv[13:0];
    return {e, o5, m5, v14};
  endfunction

  function automatic logic [W-1:0] observed();
    return {err_o, outshift_o, mcode_o, mv_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one request, optionally pulsing pmv_clear during CALC, then checks the result.
  task automatic send(input string tag, input logic [BUF_W-1:0] b, input logic [1:0] c,
                      input logic [3:0] f, input logic clr, input logic [W-1:0] exp);
    int n;
    logic [W-1:0] e;
    exp_q.push_back(exp);
    buf_i = b; ch_i = c; f_code_i = f; in_valid_i = 1'b1;
    n = 0;
    while (!in_ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
    check({tag, "_rdy"}, {31'd0, in_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    in_valid_i  = 1'b0;
    pmv_clear_i = clr;
    n = 0;
    do begin @(posedge clk_i); #1; n++; end while (!out_valid_o && n < 20);
    pmv_clear_i = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'd1);
    e = exp_q.pop_front();
    check(tag, 32'(observed()), 32'(e));
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] snap;
    logic [W-1:0] e;
    int n;
    rst_ni = 1'b0; buf_i = '0; in_valid_i = 1'b0; ch_i = '0; f_code_i = 4'd1;
    pmv_clear_i = 1'b0; out_ready_i = 1'b1;
    #12;
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_outputs", 32'(observed()), 32'(ex(1'b0, 0, 0, 0)));
    @(negedge clk_i); rst_ni = 1'b1; #1;
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk_i); #1;

    send("zero",     24'h800000, 2'd0, 4'd1, 1'b0, ex(1'b0, 1, 0, 0));
    send("neg2",     24'h300000, 2'd0, 4'd1, 1'b0, ex(1'b0, 4, -2, -2));
    send("resid",    24'h500000, 2'd1, 4'd2, 1'b0, ex(1'b0, 4, 1, 2));
    send("pos15",    24'h030000, 2'd2, 4'd1, 1'b0, ex(1'b0, 11, 15, 15));
    send("wrap_hi",  24'h400000, 2'd2, 4'd1, 1'b0, ex(1'b0, 3, 1, -16));
    pmv_clear_i = 1'b1; @(posedge clk_i); #1; pmv_clear_i = 1'b0;
    send("clr_zero", 24'h800000, 2'd2, 4'd1, 1'b0, ex(1'b0, 1, 0, 0));
    send("clr_inc",  24'h400000, 2'd2, 4'd1, 1'b0, ex(1'b0, 3, 1, 1));
    send("ch0_neg",  24'h300000, 2'd0, 4'd1, 1'b0, ex(1'b0, 4, -2, -2));
    send("bad_code", 24'h000000, 2'd0, 4'd1, 1'b0, ex(1'b1, 0, 0, -2));
    send("after_bad",24'h400000, 2'd0, 4'd1, 1'b0, ex(1'b0, 3, 1, -1));
    send("ch1_res",  24'h500000, 2'd1, 4'd2, 1'b0, ex(1'b0, 4, 1, 2));
    send("fcode0",   24'h400000, 2'd1, 4'd0, 1'b0, ex(1'b1, 0, 0, 2));
    send("fcode10",  24'h400000, 2'd1, 4'd10, 1'b0, ex(1'b1, 0, 0, 2));
    send("after_f",  24'h400000, 2'd1, 4'd1, 1'b0, ex(1'b0, 3, 1, 3));
    send("neg15",    24'h032000, 2'd3, 4'd1, 1'b0, ex(1'b0, 11, -15, -15));
    send("wrap_lo",  24'h300000, 2'd3, 4'd1, 1'b0, ex(1'b0, 4, -2, 15));
    send("f9_res",   24'h5FE000, 2'd3, 4'd9, 1'b0, ex(1'b0, 11, 1, 271));
    send("f9_max",   24'h02E000, 2'd3, 4'd9, 1'b0, ex(1'b0, 19, -16, -3570));
    send("clr_calc", 24'h400000, 2'd1, 4'd1, 1'b1, ex(1'b0, 3, 1, 1));
    send("kept_new", 24'h400000, 2'd1, 4'd1, 1'b0, ex(1'b0, 3, 1, 2));
    send("ch0_clr",  24'h400000, 2'd0, 4'd1, 1'b0, ex(1'b0, 3, 1, 1));

    // Result held with out_ready low, then reset lands mid-HOLD.
    out_ready_i = 1'b0;
    exp_q.push_back(ex(1'b0, 3, 1, 1));
    buf_i = 24'h400000; ch_i = 2'd3; f_code_i = 4'd1; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    n = 0;
    do begin @(posedge clk_i); #1; n++; end while (!out_valid_o && n < 20);
    check("hold_lat", 32'(n), 32'd1);
    e = exp_q.pop_front();
    snap = observed();
    check("hold_first", 32'(snap), 32'(e));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      check("hold_valid", {31'd0, out_valid_o}, 32'd1);
      check("hold_stable", 32'(observed()), 32'(e));
    end
    #2 rst_ni = 1'b0; #1;
    check("midrst_valid", {31'd0, out_valid_o}, 32'd0);
    check("midrst_out", 32'(observed()), 32'(ex(1'b0, 0, 0, 0)));
    @(negedge clk_i); rst_ni = 1'b1; out_ready_i = 1'b1; #1;
    check("midrst_ready", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    send("post_rst3", 24'h400000, 2'd3, 4'd1, 1'b0, ex(1'b0, 3, 1, 1));
    send("post_rst1", 24'h400000, 2'd1, 4'd1, 1'b0, ex(1'b0, 3, 1, 1));

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
